// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light controller: acks start with fb, times one phase against ts/tl limits.
// Latency: sc -> fb 1 cycle; fb -> first count 1 cycle; a limit L is reached L ticks after leaving ACK.
// Backpressure: none; sc is a held request, and each start is acknowledged by a single-cycle fb pulse.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-low reset
//   tick_en       timebase enable; counting advances only when high
//   sc            start/restart request (held until fb)
//   ld_cfg        write cfg_ts/cfg_tl into the shadow limits
//   cfg_ts/cfg_tl new short/long limits
//   fb            start acknowledge pulse
//   ts/tl         short/long interval elapsed levels
//   busy          high in ACK and RUN
//   cnt           current phase count
module traffic_timer #(
    parameter int unsigned      CNT_W  = 8,
    parameter logic [CNT_W-1:0] TS_DEF = 8'd5,
    parameter logic [CNT_W-1:0] TL_DEF = 8'd30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             sc,
    input  logic             ld_cfg,
    input  logic [CNT_W-1:0] cfg_ts,
    input  logic [CNT_W-1:0] cfg_tl,
    output logic             fb,
    output logic             ts,
    output logic             tl,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] sh_ts_q;
    logic [CNT_W-1:0] sh_tl_q;
    logic [CNT_W-1:0] ts_lim_q;
    logic [CNT_W-1:0] tl_lim_q;
    logic [CNT_W-1:0] lim_max;
    logic             fb_q;
    logic             ts_q;
    logic             tl_q;
    logic             busy_q;
    logic             start;

    always_comb begin
        lim_max = (ts_lim_q >= tl_lim_q) ? ts_lim_q : tl_lim_q;
        // Counting stops at the larger limit, which never exceeds all-ones,
        // so the counter can never wrap.
        cnt_d = cnt_q;
        if (tick_en && (cnt_q < lim_max)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // sc is ignored during the single ACK cycle.
        start = sc && (state_q != S_ACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fb_q     <= 1'b0;
            ts_q     <= 1'b0;
            tl_q     <= 1'b0;
            busy_q   <= 1'b0;
            sh_ts_q  <= TS_DEF;
            sh_tl_q  <= TL_DEF;
            ts_lim_q <= TS_DEF;
            tl_lim_q <= TL_DEF;
        end else begin
            fb_q <= 1'b0;
            if (ld_cfg) begin
                sh_ts_q <= cfg_ts;
                sh_tl_q <= cfg_tl;
            end
            if (start) begin
                state_q <= S_ACK;
                fb_q    <= 1'b1;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                ts_q    <= 1'b0;
                tl_q    <= 1'b0;
                // A shadow write on this same edge is forwarded into the new phase.
                ts_lim_q <= ld_cfg ? cfg_ts : sh_ts_q;
                tl_lim_q <= ld_cfg ? cfg_tl : sh_tl_q;
            end else begin
                case (state_q)
                    S_ACK: begin
                        // No count on the edge leaving ACK; zero limits show up here.
                        state_q <= S_RUN;
                        ts_q    <= (cnt_q >= ts_lim_q);
                        tl_q    <= (cnt_q >= tl_lim_q);
                    end
                    S_RUN: begin
                        cnt_q <= cnt_d;
                        ts_q  <= (cnt_d >= ts_lim_q);
                        tl_q  <= (cnt_d >= tl_lim_q);
                        if (cnt_d >= lim_max) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold their outputs.
                    end
                endcase
            end
        end
    end

    assign fb   = fb_q;
    assign ts   = ts_q;
    assign tl   = tl_q;
    assign busy = busy_q;
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer: start/ack handshake, interval timing, shadowed config, tick gating, reset.
// Inputs are driven 1ns after each rising edge; outputs are sampled at the same point.
// Every wait is bounded; an expired bound is reported as a miscompare.
module tb_traffic_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       sc;
    logic       ld_cfg;
    logic [7:0] cfg_ts;
    logic [7:0] cfg_tl;
    logic       fb;
    logic       ts;
    logic       tl;
    logic       busy;
    logic [7:0] cnt;

    int nvec = 0;
    int nmis = 0;

    traffic_timer #(.CNT_W(8), .TS_DEF(8'd5), .TL_DEF(8'd30)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_en (tick_en),
        .sc      (sc),
        .ld_cfg  (ld_cfg),
        .cfg_ts  (cfg_ts),
        .cfg_tl  (cfg_tl),
        .fb      (fb),
        .ts      (ts),
        .tl      (tl),
        .busy    (busy),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a phase and leave the DUT in the first RUN cycle (cnt=0).
    task automatic start_phase(input string tag);
        sc = 1'b1;
        step();
        chk({tag, " fb"}, {31'd0, fb}, 32'd1);
        sc = 1'b0;
        step();
        chk({tag, " fb drop"}, {31'd0, fb}, 32'd0);
    endtask

    task automatic run_until(input string tag, input bit want_tl, input int bound);
        int n;
        n = 0;
        while (((want_tl ? tl : ts) !== 1'b1) && (n < bound)) begin
            step();
            n++;
        end
        chk({tag, " in time"}, {31'd0, (n < bound)}, 32'd1);
    endtask

    initial begin
        int k;
        int frozen_bad;
        logic [7:0] prev;

        rst = 1'b0; tick_en = 1'b1; sc = 1'b0; ld_cfg = 1'b0; cfg_ts = 8'd0; cfg_tl = 8'd0;

        // 1: reset state, default limits 5/30, fb pulse, sc ignored in ACK
        step();
        step();
        chk("reset outs", {20'd0, fb, ts, tl, busy, cnt}, 32'd0);
        rst = 1'b1;
        step();
        chk("idle outs", {20'd0, fb, ts, tl, busy, cnt}, 32'd0);
        sc = 1'b1;
        step();
        chk("t1 ack fb/busy/cnt", {22'd0, fb, busy, cnt}, {22'd0, 1'b1, 1'b1, 8'd0});
        step();  // sc still high during ACK: must go to RUN, not re-ACK
        chk("t1 sc ignored in ack", {31'd0, fb}, 32'd0);
        sc = 1'b0;
        chk("t1 run busy", {31'd0, busy}, 32'd1);
        run_until("t1 ts", 1'b0, 100);
        chk("t1 ts at cnt", {24'd0, cnt}, 32'd5);
        run_until("t1 tl", 1'b1, 100);
        chk("t1 tl at cnt", {24'd0, cnt}, 32'd30);
        chk("t1 done busy", {31'd0, busy}, 32'd0);
        step(); step(); step();
        chk("t1 done hold", {21'd0, ts, tl, busy, cnt}, {21'd0, 1'b1, 1'b1, 1'b0, 8'd30});

        // 2: restart mid-phase at cnt=12
        start_phase("t2");
        repeat (12) step();
        chk("t2 cnt12 ts/tl", {22'd0, ts, tl, cnt}, {22'd0, 1'b1, 1'b0, 8'd12});
        sc = 1'b1;
        step();
        chk("t2 restart ack", {20'd0, fb, ts, tl, busy, cnt}, {20'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
        sc = 1'b0;
        step();
        step();
        chk("t2 count resumes", {24'd0, cnt}, 32'd1);

        // 3: shadow load mid-phase does not disturb the current phase
        start_phase("t3a");
        repeat (10) step();
        cfg_ts = 8'd2; cfg_tl = 8'd4; ld_cfg = 1'b1;
        step();
        ld_cfg = 1'b0;
        run_until("t3 old tl", 1'b1, 100);
        chk("t3 old phase end", {24'd0, cnt}, 32'd30);
        start_phase("t3b");
        run_until("t3 new ts", 1'b0, 100);
        chk("t3 new ts cnt", {24'd0, cnt}, 32'd2);
        run_until("t3 new tl", 1'b1, 100);
        chk("t3 new tl cnt", {24'd0, cnt}, 32'd4);
        step();
        chk("t3 done hold", {23'd0, busy, cnt}, {23'd0, 1'b0, 8'd4});

        // 5a: limits 0/0 loaded on the restart edge itself (forwarded)
        cfg_ts = 8'd0; cfg_tl = 8'd0; ld_cfg = 1'b1; sc = 1'b1;
        step();
        chk("t5a ack", {31'd0, fb}, 32'd1);
        ld_cfg = 1'b0; sc = 1'b0;
        step();
        chk("t5a first run", {21'd0, ts, tl, busy, cnt}, {21'd0, 1'b1, 1'b1, 1'b1, 8'd0});
        step();
        chk("t5a done", {21'd0, ts, tl, busy, cnt}, {21'd0, 1'b1, 1'b1, 1'b0, 8'd0});

        // 5b: ts limit above tl limit (7/3)
        cfg_ts = 8'd7; cfg_tl = 8'd3; ld_cfg = 1'b1;
        step();
        ld_cfg = 1'b0;
        start_phase("t5b");
        run_until("t5b tl", 1'b1, 100);
        chk("t5b tl first", {22'd0, ts, busy, cnt}, {22'd0, 1'b0, 1'b1, 8'd3});
        run_until("t5b ts", 1'b0, 100);
        chk("t5b ts/done", {23'd0, busy, cnt}, {23'd0, 1'b0, 8'd7});

        // 4: 1-in-4 tick duty with limits 3/6
        cfg_ts = 8'd3; cfg_tl = 8'd6; ld_cfg = 1'b1;
        step();
        ld_cfg = 1'b0;
        sc = 1'b1;
        step();
        chk("t4 fb", {31'd0, fb}, 32'd1);
        sc = 1'b0;
        k = 0;
        frozen_bad = 0;
        prev = cnt;
        while ((tl !== 1'b1) && (k < 60)) begin
            k++;
            tick_en = ((k % 4) == 0);
            step();
            if (((k % 4) != 0) && (cnt != prev)) frozen_bad++;
            prev = cnt;
        end
        tick_en = 1'b1;
        chk("t4 tl clocks after fb", k, 32'd24);
        chk("t4 frozen on idle ticks", frozen_bad, 32'd0);
        chk("t4 cnt", {24'd0, cnt}, 32'd6);

        // 6: synchronous reset mid-run, then sc held through reset
        cfg_ts = 8'd20; cfg_tl = 8'd40; ld_cfg = 1'b1;
        step();
        ld_cfg = 1'b0;
        start_phase("t6");
        repeat (17) step();
        chk("t6 cnt17", {24'd0, cnt}, 32'd17);
        rst = 1'b0; sc = 1'b1;
        step();
        chk("t6 reset outs", {20'd0, fb, ts, tl, busy, cnt}, 32'd0);
        step();
        chk("t6 no fb in reset", {31'd0, fb}, 32'd0);
        rst = 1'b1;
        step();
        chk("t6 fb after reset", {31'd0, fb}, 32'd1);
        sc = 1'b0;
        step();
        run_until("t6 ts", 1'b0, 100);
        chk("t6 default ts", {24'd0, cnt}, 32'd5);
        run_until("t6 tl", 1'b1, 100);
        chk("t6 default tl", {24'd0, cnt}, 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Interval timer and sequencing partner for the traffic-light controller FSM.
- Accepts the controller's held start request `sc`, acknowledges it with a one-cycle `fb` pulse, then times one phase.
- Drives level outputs `ts` (short interval elapsed) and `tl` (long interval elapsed) back to the controller.
- Interval limits are runtime-programmable through a shadow register that takes effect only at the next restart, so a phase in progress is never disturbed.

Parameters:
- CNT_W, 8, width of the phase counter and of both limits.
- TS_DEF, 8'd5, reset value of the short-interval limit, in ticks.
- TL_DEF, 8'd30, reset value of the long-interval limit, in ticks.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- tick_en  input  1  timebase enable; the counter advances only on cycles with tick_en=1.
- sc  input  1  start request from the controller; held high until fb is seen.
- ld_cfg  input  1  load cfg_ts/cfg_tl into the shadow limit registers.
- cfg_ts  input  CNT_W  new short limit.
- cfg_tl  input  CNT_W  new long limit.
- fb  output  1  start acknowledge; registered one-cycle pulse.
- ts  output  1  short interval elapsed (level).
- tl  output  1  long interval elapsed (level).
- busy  output  1  high in ACK and RUN.
- cnt  output  CNT_W  current phase count.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; cnt=0; fb=0, ts=0, tl=0, busy=0.
  - Shadow and active limits set to TS_DEF and TL_DEF.
  - Reset overrides everything, including mid-phase and during ACK.
- States: IDLE, ACK, RUN, DONE.
- IDLE:
  - Outputs low, cnt held at 0.
  - sc=1 -> ACK.
- ACK (exactly one cycle):
  - fb=1, busy=1, cnt=0, ts=0, tl=0.
  - Active limits are loaded from the shadow registers at the edge entering ACK.
  - sc is ignored while in ACK.
  - Always -> RUN at the next edge.
- RUN:
  - On each edge with tick_en=1, cnt increments by 1.
  - ts = (cnt >= ts_lim); tl = (cnt >= tl_lim). Both are registered, so they reflect cnt after the edge.
  - When cnt reaches max(ts_lim, tl_lim), or all-ones, -> DONE.
  - The counter never wraps.
- DONE:
  - cnt held; ts=1 and tl=1 held; busy=0.
  - Levels persist until the next restart.
- Restart: sc=1 in RUN or DONE -> ACK next edge (ts/tl clear there). This is the normal path whenever the controller changes state.
- Latency:
  - sc rising (sampled) to fb=1: 1 cycle.
  - fb to first possible count: 1 cycle.
  - A limit of L is reached L ticks after leaving ACK.
- Zero limits:
  - ts_lim=0 -> ts=1 on the first RUN cycle.
  - Both limits 0 -> ts=tl=1 and DONE after one RUN cycle, with cnt=0.
- ts_lim > tl_lim is legal: tl asserts first, and the timer stays in RUN until ts_lim.
- ld_cfg:
  - Accepted in any state and writes the shadow registers only.
  - ld_cfg on the same edge as entry to ACK: the new values are used for that phase (shadow write forwards to the active load).
- tick_en=0 freezes cnt in RUN; the ACK and restart transitions do not depend on tick_en.
- sc and ld_cfg are treated as synchronous to clk; the block adds no synchronisers.

Test Plan:
1. Reset with defaults, tick_en=1, pulse sc held until fb -> fb high exactly 1 cycle, 1 cycle after sc; ts rises at cnt=5; tl rises at cnt=30; state DONE, cnt holds 30; busy=0.
2. Restart mid-phase: at cnt=12 (ts=1, tl=0) assert sc -> next cycle ACK with fb=1, ts=tl=0, cnt=0; counting resumes from 0.
3. Config shadowing: ld_cfg with cfg_ts=2, cfg_tl=4 at cnt=10 of a default phase -> current phase still ends at 30; after the next restart, ts at cnt=2 and tl at cnt=4.
4. tick_en duty 1-in-4 with limits 3/6 -> tl asserts 24 clocks (±3) after fb; cnt frozen on non-tick cycles.
5. Limits 0/0 -> ts=tl=1 on the first cycle after ACK; DONE with cnt=0. Limits 7/3 -> tl at cnt=3, ts at cnt=7, DONE at 7.
6. Synchronous reset: rst=0 during RUN at cnt=17 -> next edge all outputs 0, cnt=0, limits back to 5/30; rst held low while sc=1 -> no fb until rst returns high.
